// File: rtl/sumador_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package sumador_serial_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sumador.sv
// One-bit full adder cell used by the serial adder datapath.
module sumador (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sumador_serial.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, WIDTH clocks per add.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accepting edge
//   RUN   | one bit per edge, LSB first, for WIDTH edges
//   DONE  | S/Cout just loaded, done pulse for one cycle, then back to IDLE
module sumador_serial
   import sumador_serial_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             sum_bit;
   logic             carry_nxt;

   sumador u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (sum_bit),
      .cout (carry_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         r_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         S     <= '0;
         Cout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  carry <= 1'b0;
                  cnt   <= '0;
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
               r_sh  <= {sum_bit, r_sh[WIDTH-1:1]};
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= carry_nxt;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  S     <= {sum_bit, r_sh[WIDTH-1:1]};
                  Cout  <= carry_nxt;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sumador_serial.sv
// Directed self-checking bench for sumador_serial with WIDTH=4.
module tb_sumador_serial;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic [3:0] S;
   logic       Cout;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   sumador_serial #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .S     (S),
      .Cout  (Cout),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called in an IDLE cycle; returns results sampled in the DONE cycle and
   // leaves the bench positioned in the following IDLE cycle.
   task automatic do_add(input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] s_o, output logic c_o, output int at_cyc);
      int lat;
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, 4);
      s_o    = S;
      c_o    = Cout;
      at_cyc = cyc;
      @(posedge clk); #1;
   endtask

   logic [3:0] s_r;
   logic       c_r;
   int         t1, t2, dones;
   logic [4:0] ref_sum;

   initial begin
      rst = 1'b1; start = 1'b0; A = '0; B = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s", S, 0);
      chk("rst_cout", Cout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_add(4'd15, 4'd15, s_r, c_r, t1);
      chk("s_15_15", s_r, 14);
      chk("c_15_15", c_r, 1);

      // 3+4 cycle by cycle: busy for 4 cycles, S holds previous value meanwhile
      A = 4'd3; B = 4'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("busy_3_4", busy, 1);
         chk("hold_3_4", S, 14);
         chk("nodone_3_4", done, 0);
         @(posedge clk); #1;
      end
      chk("done_3_4", done, 1);
      chk("busyoff_3_4", busy, 0);
      chk("s_3_4", S, 7);
      chk("c_3_4", Cout, 0);
      @(posedge clk); #1;
      chk("pulse_3_4", done, 0);

      do_add(4'd15, 4'd1, s_r, c_r, t1);
      chk("s_15_1", s_r, 0);
      chk("c_15_1", c_r, 1);
      do_add(4'd0, 4'd0, s_r, c_r, t1);
      chk("s_0_0", s_r, 0);
      chk("c_0_0", c_r, 0);

      // 9+5 with start held and operands wiggling during RUN and DONE
      A = 4'd9; B = 4'd5; start = 1'b1;
      @(posedge clk); #1;
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         A = 4'($urandom_range(15));
         B = 4'($urandom_range(15));
         chk("busy_9_5", busy, 1);
         if (done) dones++;
         @(posedge clk); #1;
      end
      if (done) dones++;
      chk("done_9_5", done, 1);
      chk("s_9_5", S, 14);
      chk("c_9_5", Cout, 0);
      @(posedge clk); #1;
      chk("idle_9_5", busy, 0);
      if (done) dones++;
      start = 1'b0;
      @(posedge clk); #1;
      chk("still_idle_9_5", busy, 0);
      chk("one_pulse_9_5", dones, 1);

      // reset at the second RUN cycle of 7+8
      A = 4'd7; B = 4'd8; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_s", S, 0);
      chk("abort_cout", Cout, 0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      chk("abort_nodone", dones, 0);

      // reset wins over start on the same edge
      A = 4'd1; B = 4'd1; start = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      chk("rst_prio_busy", busy, 0);
      @(posedge clk); #1;
      chk("rst_prio_idle", busy, 0);

      // back-to-back
      do_add(4'd6, 4'd6, s_r, c_r, t1);
      chk("s_6_6", s_r, 12);
      chk("c_6_6", c_r, 0);
      do_add(4'd10, 4'd7, s_r, c_r, t2);
      chk("s_10_7", s_r, 1);
      chk("c_10_7", c_r, 1);
      chk("gap_b2b", t2 - t1, 6);

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            ref_sum = 5'(a) + 5'(b);
            do_add(4'(a), 4'(b), s_r, c_r, t1);
            chk("ex_s", s_r, ref_sum[3:0]);
            chk("ex_cout", c_r, ref_sum[4]);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
